// File: rtl/note_sequencer.sv
// Melody playback sequencer feeding the 12-key octave synth.
// Optional octave transpose input: define SEQ_TRANSPOSE_EN.
module note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TICK_CLKS = 1000000,
    parameter int GAP_TICKS = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
`ifdef SEQ_TRANSPOSE_EN
    input  logic [2:0]               transpose,
`endif
    output logic [11:0]              piano_keys,
    output logic [2:0]               octave_num,
    output logic                     play_en,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] cur_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CLKS - 1);
    localparam logic [7:0]    GAP_LOAD  = 8'(GAP_TICKS);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam bit            HAS_GAP   = (GAP_TICKS > 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        PLAY,
        GAP,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    state_t        adv_state;

    logic [15:0]   mem [DEPTH];
    logic [15:0]   rd_data;
    logic [AW-1:0] idx;
    logic [PW-1:0] presc;
    logic [7:0]    dur_cnt;
    logic [3:0]    note;
    logic [11:0]   key_dec;
    logic [2:0]    oct_calc;
    logic          tick_end;
    logic          last_tick;
    logic          halt;

    assign note      = rd_data[11:8];
    assign tick_end  = (presc == PRESC_MAX);
    assign last_tick = tick_end && (dur_cnt == 8'd1);
    assign halt      = stop && (state != IDLE);

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign cur_idx = idx;

    // Note memory: host writes only while idle, registered read of idx
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[idx];
    end

    // One-hot key decode; rests and indices 12-15 are silent
    always_comb begin
        key_dec = '0;
        if (!rd_data[15] && note < 4'd12)
            key_dec = 12'd1 << note;
    end

`ifdef SEQ_TRANSPOSE_EN
    logic signed [4:0] oct_sum;

    // Transposed octave, clamped to the synth's 0..7 range
    always_comb begin
        oct_sum  = $signed({2'b00, rd_data[14:12]})
                 + $signed({{2{transpose[2]}}, transpose});
        oct_calc = oct_sum[2:0];
        if (oct_sum < 5'sd0)
            oct_calc = 3'd0;
        else if (oct_sum > 5'sd7)
            oct_calc = 3'd7;
    end
`else
    assign oct_calc = rd_data[14:12];
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; stop overrides everything outside IDLE
    always_comb begin
        state_nx  = state;
        adv_state = (idx != LAST_IDX || loop_en) ? FETCH : FIN;
        case (state)
            IDLE: begin
                if (start && !stop)
                    state_nx = FETCH;
            end
            FETCH: state_nx = EVAL;
            EVAL: begin
                if (rd_data[7:0] == 8'd0)
                    state_nx = FIN;
                else
                    state_nx = PLAY;
            end
            PLAY: begin
                if (last_tick)
                    state_nx = HAS_GAP ? GAP : adv_state;
            end
            GAP: begin
                if (last_tick)
                    state_nx = adv_state;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (halt)
            state_nx = IDLE;
    end

    // Datapath: index, prescaler, tick counter and synth outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx        <= '0;
            presc      <= '0;
            dur_cnt    <= '0;
            piano_keys <= '0;
            octave_num <= '0;
            play_en    <= 1'b0;
        end else begin
            play_en <= (state_nx != IDLE);
            if (halt) begin
                idx        <= '0;
                presc      <= '0;
                dur_cnt    <= '0;
                piano_keys <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (state_nx == FETCH) begin
                            idx   <= '0;
                            presc <= '0;
                        end
                    end
                    EVAL: begin
                        if (state_nx == PLAY) begin
                            piano_keys <= key_dec;
                            octave_num <= oct_calc;
                            dur_cnt    <= rd_data[7:0];
                            presc      <= '0;
                        end
                    end
                    PLAY, GAP: begin
                        if (tick_end) begin
                            presc   <= '0;
                            dur_cnt <= dur_cnt - 8'd1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (last_tick) begin
                            piano_keys <= '0;
                            if (state_nx == GAP)
                                dur_cnt <= GAP_LOAD;
                            if (state_nx == FETCH)
                                idx <= idx + 1'b1;
                        end
                    end
                    FIN: piano_keys <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: output run-length segments
// are queued as expected and checked by an independent monitor.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
`ifdef SEQ_TRANSPOSE_EN
    logic [2:0]  transpose = '0;
`endif
    logic [11:0] piano_keys;
    logic [2:0]  octave_num;
    logic        play_en;
    logic        busy;
    logic        done;
    logic [1:0]  cur_idx;

    int checks = 0;
    int errors = 0;

    note_sequencer #(
        .DEPTH(4),
        .TICK_CLKS(10),
        .GAP_TICKS(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
`ifdef SEQ_TRANSPOSE_EN
        .transpose(transpose),
`endif
        .piano_keys(piano_keys),
        .octave_num(octave_num),
        .play_en(play_en),
        .busy(busy),
        .done(done),
        .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] keys;
        logic [2:0]  oct;
        logic        busy;
        logic        play;
        logic        done;
        logic [1:0]  idx;
    } obs_t;

    typedef struct {
        obs_t v;
        int   len;
    } seg_t;

    seg_t expq[$];

    function automatic obs_t mk(input logic [11:0] k, input logic [2:0] o,
                                input logic b, input logic d,
                                input logic [1:0] i);
        obs_t r;
        r.keys = k;
        r.oct  = o;
        r.busy = b;
        r.play = b;
        r.done = d;
        r.idx  = i;
        return r;
    endfunction

    // len 0 means the segment length is not checked
    task automatic seg(input logic [11:0] k, input logic [2:0] o,
                       input logic b, input logic d,
                       input logic [1:0] i, input int len);
        seg_t s;
        s.v   = mk(k, o, b, d, i);
        s.len = len;
        expq.push_back(s);
    endtask

    task automatic idle(input logic [2:0] o, input logic [1:0] i);
        seg(12'h000, o, 1'b0, 1'b0, i, 0);
    endtask

    // fetch/eval, play, gap of one sounding note
    task automatic note(input logic [2:0] po, input logic [1:0] i,
                        input logic [11:0] k, input logic [2:0] o,
                        input int plen, input int glen);
        seg(12'h000, po, 1'b1, 1'b0, i, 2);
        seg(k, o, 1'b1, 1'b0, i, plen);
        seg(12'h000, o, 1'b1, 1'b0, i, glen);
    endtask

    // fetch/eval of an end marker followed by the done cycle
    task automatic end_seq(input logic [2:0] o, input logic [1:0] i);
        seg(12'h000, o, 1'b1, 1'b0, i, 2);
        seg(12'h000, o, 1'b1, 1'b1, i, 1);
    endtask

    // Monitor: collapse outputs into run-length segments and score them
    obs_t prev_o;
    obs_t cur_o;
    int   run_len = 0;
    int   seg_n = 0;
    bit   mon_on = 1'b0;
    bit   mon_init = 1'b0;

    task automatic check_seg(input obs_t o, input int len);
        seg_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL seg%0d unexpected: keys=%h oct=%0d busy=%b play=%b done=%b idx=%0d len=%0d",
                     seg_n, o.keys, o.oct, o.busy, o.play, o.done, o.idx, len);
        end else begin
            e = expq.pop_front();
            if (o !== e.v) begin
                errors++;
                $display("FAIL seg%0d outputs: got keys=%h oct=%0d busy=%b play=%b done=%b idx=%0d, want keys=%h oct=%0d busy=%b play=%b done=%b idx=%0d",
                         seg_n, o.keys, o.oct, o.busy, o.play, o.done, o.idx,
                         e.v.keys, e.v.oct, e.v.busy, e.v.play, e.v.done, e.v.idx);
            end
            if (e.len > 0) begin
                checks++;
                if (len != e.len) begin
                    errors++;
                    $display("FAIL seg%0d length: got %0d cycles, want %0d",
                             seg_n, len, e.len);
                end
            end
        end
        seg_n++;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            cur_o = {piano_keys, octave_num, busy, play_en, done, cur_idx};
            if (!mon_init) begin
                prev_o   = cur_o;
                run_len  = 1;
                mon_init = 1'b1;
            end else if (cur_o != prev_o) begin
                check_seg(prev_o, run_len);
                prev_o  = cur_o;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_keys(input logic [11:0] v, input bit eq,
                             input string nm);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 1000) begin
            @(negedge clk);
            n++;
            hit = eq ? (piano_keys == v) : (piano_keys != v);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout, keys=%h, want %s %h",
                     nm, piano_keys, eq ? "==" : "!=", v);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: timeout, busy=%b, want 0", nm, busy);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        checks++;
        if ({piano_keys, octave_num, play_en, busy, done, cur_idx} !== '0) begin
            errors++;
            $display("FAIL reset: keys=%h oct=%0d play=%b busy=%b done=%b idx=%0d, want all 0",
                     piano_keys, octave_num, play_en, busy, done, cur_idx);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_on = 1'b1;

        // basic play: A oct2 x3, C oct3 x1, end marker
        wr(2'd0, 16'h2903);
        wr(2'd1, 16'h3001);
        wr(2'd2, 16'h0000);
        idle(3'd0, 2'd0);
        note(3'd0, 2'd0, 12'h200, 3'd2, 30, 10);
        note(3'd2, 2'd1, 12'h001, 3'd3, 10, 10);
        end_seq(3'd3, 2'd2);
        pulse_start();
        wait_idle("basic");

        // rest entry then invalid note index 13
        wr(2'd0, 16'h9002);
        wr(2'd1, 16'h4D01);
        idle(3'd3, 2'd2);
        seg(12'h000, 3'd3, 1'b1, 1'b0, 2'd0, 2);
        seg(12'h000, 3'd1, 1'b1, 1'b0, 2'd0, 30);
        seg(12'h000, 3'd1, 1'b1, 1'b0, 2'd1, 2);
        seg(12'h000, 3'd4, 1'b1, 1'b0, 2'd1, 20);
        end_seq(3'd4, 2'd2);
        pulse_start();
        wait_idle("rest");

        // full depth with loop, loop_en dropped on second pass of idx 3
        wr(2'd0, 16'h1001);
        wr(2'd1, 16'h1101);
        wr(2'd2, 16'h1201);
        wr(2'd3, 16'h1301);
        idle(3'd4, 2'd2);
        note(3'd4, 2'd0, 12'h001, 3'd1, 10, 10);
        note(3'd1, 2'd1, 12'h002, 3'd1, 10, 10);
        note(3'd1, 2'd2, 12'h004, 3'd1, 10, 10);
        note(3'd1, 2'd3, 12'h008, 3'd1, 10, 10);
        for (int i = 0; i < 4; i++)
            note(3'd1, 2'(i), 12'd1 << i, 3'd1, 10, 10);
        seg(12'h000, 3'd1, 1'b1, 1'b1, 2'd3, 1);
        loop_en = 1'b1;
        pulse_start();
        wait_keys(12'h008, 1'b1, "loop_idx3_a");
        wait_keys(12'h008, 1'b0, "loop_idx3_gap");
        wait_keys(12'h008, 1'b1, "loop_idx3_b");
        loop_en = 1'b0;
        wait_idle("loop");

        // stop during entry 1, then restart from entry 0
        idle(3'd1, 2'd3);
        note(3'd1, 2'd0, 12'h001, 3'd1, 10, 10);
        seg(12'h000, 3'd1, 1'b1, 1'b0, 2'd1, 2);
        seg(12'h002, 3'd1, 1'b1, 1'b0, 2'd1, 2);
        idle(3'd1, 2'd0);
        note(3'd1, 2'd0, 12'h001, 3'd1, 10, 10);
        note(3'd1, 2'd1, 12'h002, 3'd1, 10, 10);
        note(3'd1, 2'd2, 12'h004, 3'd1, 10, 10);
        note(3'd1, 2'd3, 12'h008, 3'd1, 10, 10);
        seg(12'h000, 3'd1, 1'b1, 1'b1, 2'd3, 1);
        pulse_start();
        wait_keys(12'h002, 1'b1, "stop_wait");
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        repeat (4) @(negedge clk);
        pulse_start();
        wait_idle("restart");

        // end marker at entry 0
        wr(2'd0, 16'h0000);
        idle(3'd1, 2'd3);
        end_seq(3'd1, 2'd0);
        pulse_start();
        wait_idle("marker0");

        // start together with stop in IDLE
        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || play_en !== 1'b0) begin
            errors++;
            $display("FAIL start_stop: busy=%b play=%b, want 0 0",
                     busy, play_en);
        end

        // writes during PLAY are dropped; verified by replay
        wr(2'd0, 16'h2903);
        wr(2'd1, 16'h0000);
        idle(3'd1, 2'd0);
        note(3'd1, 2'd0, 12'h200, 3'd2, 30, 10);
        end_seq(3'd2, 2'd1);
        pulse_start();
        wait_keys(12'h200, 1'b1, "wr_play_wait");
        wr(2'd0, 16'h3001);
        wr(2'd1, 16'h5101);
        wait_idle("wr_play");
        idle(3'd2, 2'd1);
        note(3'd2, 2'd0, 12'h200, 3'd2, 30, 10);
        end_seq(3'd2, 2'd1);
        pulse_start();
        wait_idle("replay");

`ifdef SEQ_TRANSPOSE_EN
        // octave saturation at both ends
        wr(2'd0, 16'h6001);
        wr(2'd1, 16'h1101);
        wr(2'd2, 16'h0000);
        idle(3'd2, 2'd1);
        note(3'd2, 2'd0, 12'h001, 3'd7, 10, 10);
        note(3'd7, 2'd1, 12'h002, 3'd0, 10, 10);
        end_seq(3'd0, 2'd2);
        transpose = 3'b011;
        pulse_start();
        wait_keys(12'h001, 1'b1, "transpose_wait");
        transpose = 3'b100;
        wait_idle("transpose");
        transpose = 3'b000;
`endif

        repeat (5) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expected segments not seen, want 0",
                     expq.size());
        end

        // asynchronous reset while a note sounds
        mon_on = 1'b0;
        pulse_start();
        wait_keys(12'h000, 1'b0, "areset_wait");
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({piano_keys, octave_num, play_en, busy, done, cur_idx} !== '0) begin
            errors++;
            $display("FAIL async_reset: keys=%h oct=%0d play=%b busy=%b done=%b idx=%0d, want all 0",
                     piano_keys, octave_num, play_en, busy, done, cur_idx);
        end
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
